// File: rtl/e203_clkgate_ctrl.sv
// e203_clkgate_ctrl: clock-gate controller for one gated domain.
// The domain stays clocked while any wake request is present or it reports
// busy work. After IDLE_CYC quiet cycles it asks the domain to quiesce
// (gate_req), then stops the clock once the domain acknowledges. A wake
// request restarts the clock, and ready returns after WAKE_CYC cycles.
// test_mode forces the clock on combinationally and steers the FSM to RUN.
// Optional build macro: E203_CLKGATE_CTRL_STAT_EN adds the gated_cnt output,
// which counts the cycles spent with the clock stopped.
module e203_clkgate_ctrl #(
    parameter int NREQ     = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] wake_req,
    input  logic            busy,
    input  logic            gate_ack,
    input  logic            test_mode,
    output logic            gate_req,
    output logic            clock_en,
    output logic            ready,
    output logic [3:0]      wake_src
`ifdef E203_CLKGATE_CTRL_STAT_EN
    ,
    output logic [31:0]     gated_cnt
`endif
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        IDLE  = 3'd1,
        DRAIN = 3'd2,
        OFF   = 3'd3,
        WAKE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [3:0]  wake_cnt_q, wake_cnt_d;
    logic [3:0]  wake_src_q, wake_src_d;
    logic        clk_en_q, clk_en_d;
    logic        gate_req_q, gate_req_d;
    logic        ready_q, ready_d;
    logic [3:0]  lsb_idx;
    logic        any_wake;

    assign any_wake = |wake_req;

    // Index of the lowest set wake request; scanning downward lets the
    // lowest index win.
    always_comb begin
        lsb_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (wake_req[i]) lsb_idx = 4'(i);
        end
    end

    // Next-state logic. The outputs are decoded from the next state so that
    // the output registers always agree with the state register.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        wake_src_d = wake_src_q;
        unique case (state_q)
            RUN: begin
                if (!test_mode && !any_wake && !busy) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end
            end
            IDLE: begin
                if (test_mode || any_wake || busy) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == 8'(IDLE_CYC - 1)) begin
                    state_d    = DRAIN;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            DRAIN: begin
                // A wake request aborts the drain even if the ack arrives together with it.
                if (test_mode || any_wake) state_d = RUN;
                else if (gate_ack)         state_d = OFF;
            end
            OFF: begin
                if (any_wake || test_mode) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                    if (any_wake) wake_src_d = lsb_idx;
                end
            end
            WAKE: begin
                // The clock needs the full settle time here, so wake_req and test_mode are ignored.
                if (wake_cnt_q == 4'(WAKE_CYC - 1)) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: state_d = WAKE;
        endcase
        if (test_mode) idle_cnt_d = '0;

        clk_en_d   = (state_d != OFF);
        gate_req_d = (state_d == DRAIN);
        ready_d    = (state_d == RUN) || (state_d == IDLE) || (state_d == DRAIN);
    end

    // State and output registers. Reset lands in WAKE, so the clock is
    // re-enabled immediately and ready follows after the wake delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAKE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            wake_src_q <= '0;
            clk_en_q   <= 1'b1;
            gate_req_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            wake_src_q <= wake_src_d;
            clk_en_q   <= clk_en_d;
            gate_req_q <= gate_req_d;
            ready_q    <= ready_d;
        end
    end

    // test_mode bypasses the register so the clock restarts without waiting for an edge.
    assign clock_en = clk_en_q | test_mode;
    assign gate_req = gate_req_q;
    assign ready    = ready_q;
    assign wake_src = wake_src_q;

`ifdef E203_CLKGATE_CTRL_STAT_EN
    logic [31:0] gated_cnt_q;

    // Saturating count of cycles spent with the clock stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      gated_cnt_q <= '0;
        else if (state_q == OFF && gated_cnt_q != '1) gated_cnt_q <= gated_cnt_q + 32'd1;
    end

    assign gated_cnt = gated_cnt_q;
`endif

endmodule

// File: tb/tb_e203_clkgate_ctrl.sv
// Directed bench for e203_clkgate_ctrl with default parameters
// (NREQ=4, IDLE_CYC=16, WAKE_CYC=2). Inputs are driven and outputs are
// sampled 1ns after each rising edge.
module tb_e203_clkgate_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wake_req;
    logic       busy, gate_ack, test_mode;
    logic       gate_req, clock_en, ready;
    logic [3:0] wake_src;
`ifdef E203_CLKGATE_CTRL_STAT_EN
    logic [31:0] gated_cnt;
`endif

    int checks = 0;
    int errors = 0;

    e203_clkgate_ctrl #(.NREQ(4), .IDLE_CYC(16), .WAKE_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wake_req  (wake_req),
        .busy      (busy),
        .gate_ack  (gate_ack),
        .test_mode (test_mode),
        .gate_req  (gate_req),
        .clock_en  (clock_en),
        .ready     (ready),
        .wake_src  (wake_src)
`ifdef E203_CLKGATE_CTRL_STAT_EN
        ,
        .gated_cnt (gated_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset state, then release: ready must rise exactly at cycle 2.
    task automatic test_reset;
        rst = 1'b1; wake_req = '0; busy = 1'b0; gate_ack = 1'b0; test_mode = 1'b0;
        tick(3);
        checks++; if (clock_en !== 1'b1) begin errors++; $display("FAIL rst_clock_en got %b exp 1", clock_en); end
        checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL rst_ready got %b exp 0", ready); end
        checks++; if (gate_req !== 1'b0) begin errors++; $display("FAIL rst_gate_req got %b exp 0", gate_req); end
        checks++; if (wake_src !== 4'd0) begin errors++; $display("FAIL rst_wake_src got %0d exp 0", wake_src); end
        rst = 1'b0;
        tick(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rel_ready_c1 got %b exp 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready_c2 got %b exp 1", ready); end
    endtask

    // Starts in RUN at cycle 2: gate_req must be low at cycle 18 and high at
    // cycle 19; after the ack, the clock stops one cycle later.
    task automatic test_idle_gate;
        tick(16);
        checks++; if (gate_req !== 1'b0) begin errors++; $display("FAIL gate_early got %b exp 0", gate_req); end
        tick(1);
        checks++; if (gate_req !== 1'b1 || clock_en !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL drain_outs got req=%b en=%b rdy=%b exp 1 1 1", gate_req, clock_en, ready); end
        gate_ack = 1'b1;
        tick(1);
        gate_ack = 1'b0;
        checks++; if (clock_en !== 1'b0 || ready !== 1'b0 || gate_req !== 1'b0) begin
            errors++; $display("FAIL off_outs got en=%b rdy=%b req=%b exp 0 0 0", clock_en, ready, gate_req); end
    endtask

    // Wake from OFF with the lowest set bit at index 1.
    task automatic test_wake;
        wake_req = 4'b0110;
        tick(1);
        wake_req = 4'b0000;
        checks++; if (wake_src !== 4'd1) begin errors++; $display("FAIL wake_src got %0d exp 1", wake_src); end
        checks++; if (clock_en !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL wake_outs got en=%b rdy=%b exp 1 0", clock_en, ready); end
        tick(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wake_ready_c1 got %b exp 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wake_ready_c2 got %b exp 1", ready); end
    endtask

    // A busy pulse at idle count 10 restarts the full 16-cycle idle window.
    task automatic test_busy_restart;
        tick(11);
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        checks++; if (gate_req !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL busy_run got req=%b rdy=%b exp 0 1", gate_req, ready); end
        tick(16);
        checks++; if (gate_req !== 1'b0) begin errors++; $display("FAIL busy_gate_early got %b exp 0", gate_req); end
        tick(1);
        checks++; if (gate_req !== 1'b1) begin errors++; $display("FAIL busy_gate got %b exp 1", gate_req); end
    endtask

    // In DRAIN, a wake request beats a simultaneous gate_ack.
    task automatic test_drain_abort;
        wake_req = 4'b1000; gate_ack = 1'b1;
        tick(1);
        wake_req = 4'b0000; gate_ack = 1'b0;
        checks++; if (gate_req !== 1'b0 || clock_en !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL abort_outs got req=%b en=%b rdy=%b exp 0 1 1", gate_req, clock_en, ready); end
        checks++; if (wake_src !== 4'd1) begin errors++; $display("FAIL abort_wake_src got %0d exp 1", wake_src); end
    endtask

    // From OFF, test_mode restarts the clock at once and blocks gating while held.
    task automatic test_test_mode;
        int bad;
        tick(17);
        checks++; if (gate_req !== 1'b1) begin errors++; $display("FAIL tm_drain got %b exp 1", gate_req); end
        gate_ack = 1'b1;
        tick(1);
        gate_ack = 1'b0;
        checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL tm_off got %b exp 0", clock_en); end
        test_mode = 1'b1;
        #1;
        checks++; if (clock_en !== 1'b1) begin errors++; $display("FAIL tm_comb_en got %b exp 1", clock_en); end
        tick(2);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL tm_ready_early got %b exp 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL tm_ready got %b exp 1", ready); end
        bad = 0;
        gate_ack = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (gate_req !== 1'b0 || clock_en !== 1'b1 || ready !== 1'b1) bad++;
        end
        gate_ack = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL tm_hold got %0d bad cycles exp 0", bad); end
        test_mode = 1'b0;
    endtask

    // Asynchronous reset in DRAIN and in OFF, plus the optional stop-cycle counter.
    task automatic test_reset_mid;
        tick(18);
        checks++; if (gate_req !== 1'b1) begin errors++; $display("FAIL rm_drain got %b exp 1", gate_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gate_req !== 1'b0 || clock_en !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL rm_drain_async got req=%b en=%b rdy=%b exp 0 1 0", gate_req, clock_en, ready); end
        tick(1);
        rst = 1'b0;
        tick(2);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_drain_ready got %b exp 1", ready); end
        tick(17);
        gate_ack = 1'b1;
        tick(1);
        gate_ack = 1'b0;
        checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL rm_off got %b exp 0", clock_en); end
        tick(50);
`ifdef E203_CLKGATE_CTRL_STAT_EN
        checks++; if (gated_cnt !== 32'd50) begin errors++; $display("FAIL gated_cnt got %0d exp 50", gated_cnt); end
`endif
        #2 rst = 1'b1;
        #1;
        checks++; if (clock_en !== 1'b1 || ready !== 1'b0 || wake_src !== 4'd0) begin
            errors++; $display("FAIL rm_off_async got en=%b rdy=%b src=%0d exp 1 0 0", clock_en, ready, wake_src); end
`ifdef E203_CLKGATE_CTRL_STAT_EN
        checks++; if (gated_cnt !== 32'd0) begin errors++; $display("FAIL gated_cnt_rst got %0d exp 0", gated_cnt); end
`endif
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_off_ready_c1 got %b exp 0", ready); end
        tick(1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_off_ready_c2 got %b exp 1", ready); end
    endtask

    initial begin
        test_reset();
        test_idle_gate();
        test_wake();
        test_busy_restart();
        test_drain_abort();
        test_test_mode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
